// File: rtl/crossing_scheduler.sv
// crossing_scheduler: round-robin pedestrian crossing sequencer against the main-road light
module crossing_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int N_REQ     = 4,
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 7,
  parameter int CLEAR_T   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_btn,
  output logic [2:0]       road_light,
  output logic [N_REQ-1:0] walk_sel,
  output logic             walk_on,
  output logic             walk_flash,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic [2:0]       phase
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [2:0] {GREEN = 3'd0, YELLOW = 3'd1, ALLRED = 3'd2, WALK = 3'd3, CLEAR = 3'd4} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt;
  logic [15:0] tmr, tmr_n, lim;
  logic [N_REQ-1:0] s1, s2, s3, grant, grant_n, pend_n;
  logic [PW-1:0] ptr, ptr_n, win;
  logic tick, done, flash_n, illegal;
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign phase = st;
  assign lim = st == YELLOW ? 16'(YELLOW_T - 1) : st == ALLRED ? 16'(ALLRED_T - 1) :
               st == WALK ? 16'(WALK_T - 1) : 16'(CLEAR_T - 1);
  assign done = tick && tmr == lim;
  // round-robin winner: first pending bit after ptr, wrapping; lowest offset wins
  always_comb begin
    win = ptr;
    for (int k = N_REQ; k >= 1; k--)
      if (pending[(int'(ptr) + k) % N_REQ]) win = PW'((int'(ptr) + k) % N_REQ);
  end
  // next phase, grant latch, phase timer, flash and pending bookkeeping
  always_comb begin
    st_n = st;
    grant_n = grant;
    ptr_n = ptr;
    illegal = 1'b0;
    case (st)
      GREEN: if (tick && tmr >= 16'(MIN_GREEN - 1) && |pending) begin
        st_n = YELLOW;
        grant_n = N_REQ'(1) << win;
        ptr_n = win;
      end
      YELLOW: if (done) st_n = ALLRED;
      ALLRED: if (done) st_n = WALK;
      WALK:   if (done) st_n = CLEAR;
      CLEAR:  if (done) st_n = GREEN;
      default: begin
        st_n = GREEN;
        grant_n = '0;
        illegal = 1'b1;
      end
    endcase
    tmr_n = st_n != st ? '0 : !tick ? tmr : (st == GREEN && tmr >= 16'(MIN_GREEN)) ? tmr : tmr + 16'd1;
    flash_n = st_n == CLEAR && (st != CLEAR || (tick ^ walk_flash));
    pend_n = illegal ? '0 : (pending | (s2 & ~s3)) & ~((st_n == WALK && st != WALK) ? grant : '0);
  end
  // registered state and outputs, decoded from the next phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      st <= GREEN;
      tmr <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pending <= '0;
      grant <= '0;
      ptr <= PW'(N_REQ - 1);
      road_light <= 3'b001;
      walk_sel <= '0;
      walk_on <= 1'b0;
      walk_flash <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      st <= st_n;
      tmr <= tmr_n;
      s1 <= req_btn;
      s2 <= s1;
      s3 <= s2;
      pending <= pend_n;
      grant <= grant_n;
      ptr <= ptr_n;
      road_light <= st_n == GREEN ? 3'b001 : st_n == YELLOW ? 3'b010 : 3'b100;
      walk_sel <= (st_n == WALK || st_n == CLEAR) ? grant_n : '0;
      walk_on <= st_n == WALK;
      walk_flash <= flash_n;
      busy <= st_n != GREEN;
    end
  end
endmodule
